// File: rtl/serial_slave_drv_if.sv
// Signal bundle joining the slave driver to the deserializer, register file and serializer.
interface serial_slave_drv_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  rx_valid_i;
    logic [DATA_WIDTH-1:0] rx_data_i;
    logic                  reg_wr_en_o;
    logic                  reg_rd_en_o;
    logic [ADDR_WIDTH-1:0] reg_addr_o;
    logic [DATA_WIDTH-1:0] reg_wr_data_o;
    logic                  reg_rd_vld_i;
    logic [DATA_WIDTH-1:0] reg_rd_data_i;
    logic                  tx_data_num_en_o;
    logic [5:0]            tx_data_num_o;
    logic                  tx_valid_o;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  tx_ack_i;
    logic                  busy_o;
    logic                  err_o;

    modport slave (
        input  rx_valid_i, rx_data_i, reg_rd_vld_i, reg_rd_data_i, tx_ack_i,
        output reg_wr_en_o, reg_rd_en_o, reg_addr_o, reg_wr_data_o,
               tx_data_num_en_o, tx_data_num_o, tx_valid_o, tx_data_o, busy_o, err_o
    );
    modport master (
        output rx_valid_i, rx_data_i, reg_rd_vld_i, reg_rd_data_i, tx_ack_i,
        input  reg_wr_en_o, reg_rd_en_o, reg_addr_o, reg_wr_data_o,
               tx_data_num_en_o, tx_data_num_o, tx_valid_o, tx_data_o, busy_o, err_o
    );
endinterface

// File: rtl/serial_slave_drv.sv
// Serial slave: decodes header words into register write/read bursts and returns
// read data to the serializer as a counted packet.
module serial_slave_drv #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int SLAVE_SEL     = 0,
    parameter int TIMEOUT_COUNT = 4999
) (
    input logic               clk_i,
    input logic               rst_n_i,
    serial_slave_drv_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WR_DATA, SKIP, RD_REQ, RD_WAIT, TX_HDR, TX_DATA, TX_WAIT
    } state_e;

    localparam int TW = $clog2(TIMEOUT_COUNT + 1);

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d, idx_q, idx_d;
    logic [5:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d, err_q, err_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic [DATA_WIDTH-1:0] rd_buf [32];

    logic [ADDR_WIDTH-1:0] hdr_addr, offs;
    logic                  hdr_sel, hdr_wr, store, rx_accept, unused_hdr;
    logic [5:0]            hdr_n;

    assign hdr_addr   = ADDR_WIDTH'(bus.rx_data_i[31:16]);
    assign hdr_sel    = bus.rx_data_i[8 + SLAVE_SEL];
    assign hdr_wr     = bus.rx_data_i[7];
    assign hdr_n      = {1'b0, bus.rx_data_i[4:0]} + 6'd1;
    assign unused_hdr = ^{bus.rx_data_i[15:8], bus.rx_data_i[6:5]};
    assign offs       = ADDR_WIDTH'({idx_q, 2'b00});
    // Responses beyond the requested count, or outside a read, never touch the buffer
    assign store      = bus.reg_rd_vld_i && (state_q == RD_REQ || state_q == RD_WAIT)
                        && (wr_ptr_q < cnt_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_ptr_d  = store ? wr_ptr_q + 6'd1 : wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        base_d    = base_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        err_d     = 1'b0;
        rx_accept = 1'b0;
        to_cnt_d  = to_cnt_q + TW'(1);
        case (state_q)
            IDLE: if (bus.rx_valid_i) begin
                base_d = hdr_addr;
                cnt_d  = hdr_n;
                idx_d  = '0;
                if (!hdr_sel) begin
                    if (hdr_wr) state_d = SKIP;
                end else if (hdr_wr) begin
                    state_d = WR_DATA;
                end else begin
                    state_d  = RD_REQ;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            WR_DATA, SKIP: if (bus.rx_valid_i) begin
                rx_accept = 1'b1;
                idx_d     = idx_q + 6'd1;
                if (state_q == WR_DATA) begin
                    wr_en_d = 1'b1;
                    addr_d  = base_q + offs;
                    wdata_d = bus.rx_data_i;
                end
                if (idx_q + 6'd1 == cnt_q) state_d = IDLE;
            end
            RD_REQ: begin
                rd_en_d = 1'b1;
                addr_d  = base_q + offs;
                idx_d   = idx_q + 6'd1;
                if (idx_q + 6'd1 == cnt_q) state_d = RD_WAIT;
            end
            RD_WAIT: if (wr_ptr_q == cnt_q) state_d = TX_HDR;
            TX_HDR:  state_d = TX_DATA;
            TX_DATA: begin
                rd_ptr_d = rd_ptr_q + 6'd1;
                if (rd_ptr_q + 6'd1 == cnt_q) state_d = TX_WAIT;
            end
            TX_WAIT: if (bus.tx_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Words arriving while a read is in flight are dropped and flagged
        if (bus.rx_valid_i && state_q != IDLE && state_q != WR_DATA && state_q != SKIP)
            err_d = 1'b1;
        if (state_q == IDLE || state_d != state_q || rx_accept) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_COUNT - 1)) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            wr_en_d  = 1'b0;
            rd_en_d  = 1'b0;
            idx_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Data storage only; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (store) rd_buf[wr_ptr_q[4:0]] <= bus.reg_rd_data_i;
    end

    assign bus.reg_wr_en_o      = wr_en_q;
    assign bus.reg_rd_en_o      = rd_en_q;
    assign bus.reg_addr_o       = addr_q;
    assign bus.reg_wr_data_o    = wdata_q;
    assign bus.tx_data_num_en_o = (state_q == TX_HDR);
    assign bus.tx_data_num_o    = (state_q == TX_HDR) ? cnt_q : '0;
    assign bus.tx_valid_o       = (state_q == TX_DATA);
    assign bus.tx_data_o        = (state_q == TX_DATA) ? rd_buf[rd_ptr_q[4:0]] : '0;
    assign bus.busy_o           = (state_q != IDLE);
    assign bus.err_o            = err_q;
endmodule

// File: tb/tb_serial_slave_drv.sv
// Randomized packet traffic against a queue-based scoreboard, plus literal
// header scenarios for writes, reads, skips, wrap, timeout and mid-packet reset.
module tb_serial_slave_drv;
    localparam int DW = 32, AW = 16, TO = 64;

    logic clk_i = 1'b0, rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    serial_slave_drv_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    serial_slave_drv #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVE_SEL(0), .TIMEOUT_COUNT(TO))
        dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

    int total = 0, bad = 0;
    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected traffic, filled by the stimulus from the header rules
    logic [AW-1:0] exp_wa[$], exp_ra[$];
    logic [DW-1:0] exp_wd[$], exp_tx[$], preset[$];
    int            exp_num[$];
    int unsigned   pend_t[$];
    int unsigned   last_ready = 0;
    int rd_lat = 2, junk_req = 0, err_seen = 0, tx_seen = 0;
    int tx_run = 0, tx_n = 0, rd_run = 0, rd_n = 0, nn = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            tx_run = 0;
            rd_run = 0;
        end else begin
            if (bus.reg_wr_en_o && exp_wa.size() > 0) begin
                chk("wr_addr", 64'(bus.reg_addr_o), 64'(exp_wa.pop_front()));
                chk("wr_data", 64'(bus.reg_wr_data_o), 64'(exp_wd.pop_front()));
            end else if (exp_wa.size() == 0) chk("wr_en_quiet", 64'(bus.reg_wr_en_o), 64'(0));

            if (bus.reg_rd_en_o && exp_ra.size() > 0) begin
                chk("rd_addr", 64'(bus.reg_addr_o), 64'(exp_ra.pop_front()));
                last_ready = (cyc + rd_lat > last_ready + 1) ? cyc + rd_lat : last_ready + 1;
                pend_t.push_back(last_ready);
                rd_run++;
            end else begin
                if (exp_ra.size() == 0) chk("rd_en_quiet", 64'(bus.reg_rd_en_o), 64'(0));
                if (rd_run > 0) begin chk("rd_burst", 64'(rd_run), 64'(rd_n)); rd_run = 0; end
            end

            if (bus.tx_data_num_en_o && exp_num.size() > 0) begin
                nn = exp_num.pop_front();
                chk("tx_num", 64'(bus.tx_data_num_o), 64'(nn));
                tx_n = nn;
            end else if (exp_num.size() == 0) chk("tx_num_quiet", 64'(bus.tx_data_num_en_o), 64'(0));

            if (bus.tx_valid_o && exp_tx.size() > 0) begin
                chk("tx_data", 64'(bus.tx_data_o), 64'(exp_tx.pop_front()));
                tx_run++;
                tx_seen++;
            end else begin
                if (exp_tx.size() == 0) chk("tx_valid_quiet", 64'(bus.tx_valid_o), 64'(0));
                if (tx_run > 0) begin chk("tx_burst", 64'(tx_run), 64'(tx_n)); tx_run = 0; end
            end

            if (bus.err_o) err_seen++;
        end
    end

    // In-order register file: answers each read after rd_lat cycles, optional stray pulses
    initial begin
        bus.reg_rd_vld_i  = 1'b0;
        bus.reg_rd_data_i = '0;
        forever begin
            logic [DW-1:0] d;
            @(posedge clk_i); #1;
            bus.reg_rd_vld_i  = 1'b0;
            bus.reg_rd_data_i = '0;
            if (!rst_n_i) pend_t.delete();
            else if (junk_req > 0) begin
                bus.reg_rd_vld_i  = 1'b1;
                bus.reg_rd_data_i = $urandom;
                junk_req--;
            end else if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                d = (preset.size() > 0) ? preset.pop_front() : DW'($urandom);
                void'(pend_t.pop_front());
                bus.reg_rd_vld_i  = 1'b1;
                bus.reg_rd_data_i = d;
                exp_tx.push_back(d);
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk_i); #1; end
    endtask

    task automatic send(input logic [DW-1:0] w);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = w;
        tick(1);
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = '0;
    endtask

    task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    task automatic exp_read(input logic [AW-1:0] base, input int n);
        rd_n = n;
        for (int i = 0; i < n; i++) exp_ra.push_back(base + AW'(4 * i));
        exp_num.push_back(n);
    endtask

    task automatic finish_read(input int n);
        int s, k;
        s = tx_seen;
        k = 0;
        while (tx_seen - s < n && k < 600) begin tick(1); k++; end
        chk("tx_count", 64'(tx_seen - s), 64'(n));
        tick($urandom_range(0, 8));
        bus.tx_ack_i = 1'b1;
        tick(1);
        bus.tx_ack_i = 1'b0;
        chk("busy_after_ack", 64'(bus.busy_o), 64'(0));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_wa.size() + exp_ra.size() + exp_num.size() + exp_tx.size()) != 0 && k < 200) begin
            tick(1); k++;
        end
        chk("drain", 64'(exp_wa.size() + exp_ra.size() + exp_num.size() + exp_tx.size()), 64'(0));
    endtask

    task automatic rand_packet();
        logic [15:0] base;
        logic [7:0]  bsel;
        logic        typ;
        logic [DW-1:0] d;
        int n;
        base = 16'($urandom);
        bsel = 8'($urandom);
        typ  = 1'($urandom);
        n    = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 32);
        if (bsel[0] && !typ) begin
            rd_lat = $urandom_range(1, 6);
            exp_read(base, n);
        end
        send({base, bsel, typ, 2'($urandom), 5'(n - 1)});
        chk("busy_hdr", 64'(bus.busy_o), 64'(bsel[0] | typ));
        if (typ) begin
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                if (bsel[0]) exp_write(base + AW'(4 * i), d);
                tick($urandom_range(0, 3));
                send(d);
            end
            tick(2);
            chk("busy_wr_end", 64'(bus.busy_o), 64'(0));
        end else if (bsel[0]) finish_read(n);
        drain();
    endtask

    initial begin
        int e0, k, s;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = '0;
        bus.tx_ack_i   = 1'b0;
        #1;
        chk("rst_wr_en", 64'(bus.reg_wr_en_o), 64'(0));
        chk("rst_rd_en", 64'(bus.reg_rd_en_o), 64'(0));
        chk("rst_addr", 64'(bus.reg_addr_o), 64'(0));
        chk("rst_tx_valid", 64'(bus.tx_valid_o), 64'(0));
        chk("rst_num_en", 64'(bus.tx_data_num_en_o), 64'(0));
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_err", 64'(bus.err_o), 64'(0));
        tick(2);
        rst_n_i = 1'b1;
        tick(1);

        // Two-word write; an ack while writing must be ignored
        e0 = err_seen;
        exp_write(16'h4000, 32'h1111_1111);
        exp_write(16'h4004, 32'h2222_2222);
        send(32'h4000_0181);
        send(32'h1111_1111);
        bus.tx_ack_i = 1'b1; tick(1); bus.tx_ack_i = 1'b0;
        send(32'h2222_2222);
        tick(2);
        chk("wr2_busy", 64'(bus.busy_o), 64'(0));
        drain();
        chk("wr2_err", 64'(err_seen - e0), 64'(0));

        // Stray read-valid pulses while idle, then a three-word read
        junk_req = 2;
        tick(4);
        rd_lat = 3;
        preset.push_back(32'hA); preset.push_back(32'hB); preset.push_back(32'hC);
        exp_ra.push_back(16'h0010); exp_ra.push_back(16'h0014); exp_ra.push_back(16'h0018);
        exp_num.push_back(3);
        rd_n = 3;
        send(32'h0010_0102);
        finish_read(3);
        drain();

        // Unselected write is skipped, then a one-word read
        send(32'h4000_0281);
        chk("skip_busy", 64'(bus.busy_o), 64'(1));
        send(32'hDEAD_0001);
        send(32'hDEAD_0002);
        chk("skip_done", 64'(bus.busy_o), 64'(0));
        exp_ra.push_back(16'h4000);
        exp_num.push_back(1);
        rd_n = 1;
        send(32'h4000_0100);
        finish_read(1);
        drain();

        // Short write times out, wrap-around write, then timed timeout
        e0 = err_seen;
        exp_write(16'hFFFC, 32'h0000_0F0F);
        send(32'hFFFC_0181);
        send(32'h0000_0F0F);
        k = 0;
        while (err_seen == e0 && k < 200) begin tick(1); k++; end
        chk("to1_err", 64'(err_seen - e0), 64'(1));
        chk("to1_busy", 64'(bus.busy_o), 64'(0));
        exp_write(16'hFFFC, 32'h1); exp_write(16'h0000, 32'h2); exp_write(16'h0004, 32'h3);
        send(32'hFFFC_0182);
        send(32'h1); send(32'h2); send(32'h3);
        tick(2);
        chk("wrap_busy", 64'(bus.busy_o), 64'(0));
        drain();
        exp_write(16'h1000, 32'h7777_7777);
        send(32'h1000_0183);
        send(32'h7777_7777);
        // err rises TIMEOUT_COUNT edges after the edge that accepted the last word
        k = 0;
        while (!bus.err_o && k < 200) begin tick(1); k++; end
        chk("to2_cycles", 64'(k), 64'(TO));
        chk("to2_busy", 64'(bus.busy_o), 64'(0));
        tick(1);
        chk("to2_pulse", 64'(bus.err_o), 64'(0));
        drain();

        // Word arriving during a read burst is dropped with an error pulse
        e0 = err_seen;
        rd_lat = 6;
        exp_read(16'h2340, 4);
        send(32'h2340_0103);
        send(32'h9999_9999);
        finish_read(4);
        drain();
        chk("drop_err", 64'(err_seen - e0), 64'(1));

        for (int p = 0; p < 40; p++) rand_packet();

        // Reset in the middle of a 32-word response
        rd_lat = 2;
        exp_read(16'h8000, 32);
        send(32'h8000_011F);
        s = tx_seen;
        k = 0;
        while (tx_seen - s < 5 && k < 300) begin tick(1); k++; end
        chk("pre_reset_tx", 64'(tx_seen - s), 64'(5));
        #1 rst_n_i = 1'b0;
        #1;
        chk("rst_mid_tx_valid", 64'(bus.tx_valid_o), 64'(0));
        chk("rst_mid_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_mid_rd_en", 64'(bus.reg_rd_en_o), 64'(0));
        exp_tx.delete(); exp_num.delete(); exp_ra.delete(); preset.delete();
        tick(2);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 32'h2000_0180;
        rst_n_i = 1'b1;
        tick(1);
        bus.rx_valid_i = 1'b0;
        chk("post_rst_hdr", 64'(bus.busy_o), 64'(1));
        exp_write(16'h2000, 32'h5A5A_5A5A);
        send(32'h5A5A_5A5A);
        tick(2);
        chk("post_rst_busy", 64'(bus.busy_o), 64'(0));
        drain();

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end
endmodule
